// File: rtl/dac_spdif_bridge.sv
// dac_spdif_bridge: stereo rate-decoupling FIFO between the DAC deserializer and the S/PDIF transmitter
module dac_spdif_bridge #(
  parameter int DEPTH_LOG2    = 4,
  parameter int PREFILL       = 8,
  parameter bit MUTE_ON_EMPTY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [15:0]           in_left,
  input  logic [15:0]           in_right,
  input  logic                  chan_sel,
  input  logic                  clear_counts,
  output logic [15:0]           out_sample,
  output logic [15:0]           out_left,
  output logic [15:0]           out_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic [15:0]           ovf_count,
  output logic [15:0]           unf_count
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(2 ** DEPTH_LOG2);
  localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);
  typedef enum logic {FILL, RUN} state_e;
  state_e state_q, state_d;
  logic [31:0] mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic chan_q;
  logic [15:0] left_q, left_d, right_q, right_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0] head;
  logic pop, full, empty, rd, wr, ovf_inc, unf_inc, hold;
  // Head is read through the registered read pointer, so it is valid one cycle after its write
  always_comb begin
    pop      = chan_q & ~chan_sel;
    full     = level_q == FULL_LVL;
    empty    = level_q == '0;
    rd       = pop && state_q == RUN && !empty;
    unf_inc  = pop && state_q == RUN && empty;
    wr       = in_valid && (!full || rd);
    ovf_inc  = in_valid && !wr;
    head     = mem[rd_ptr_q];
    hold     = unf_inc && !MUTE_ON_EMPTY;
    wr_ptr_d = wr ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    level_d  = level_q + LW'(wr) - LW'(rd);
    state_d  = unf_inc ? FILL : (state_q == FILL && level_d >= PRE_LVL) ? RUN : state_q;
    left_d   = !pop ? left_q  : rd ? head[31:16] : hold ? left_q  : 16'h0;
    right_d  = !pop ? right_q : rd ? head[15:0]  : hold ? right_q : 16'h0;
    ovf_d    = clear_counts ? 16'h0 : (ovf_inc && ovf_q != 16'hFFFF) ? ovf_q + 16'h1 : ovf_q;
    unf_d    = clear_counts ? 16'h0 : (unf_inc && unf_q != 16'hFFFF) ? unf_q + 16'h1 : unf_q;
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= {in_left, in_right};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      chan_q   <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      chan_q   <= chan_sel;
      left_q   <= left_d;
      right_q  <= right_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  assign out_left   = left_q;
  assign out_right  = right_q;
  assign out_sample = chan_sel ? left_q : right_q;
  assign level      = level_q;
  assign running    = state_q == RUN;
  assign ovf_count  = ovf_q;
  assign unf_count  = unf_q;
endmodule
